// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide request controller.
package md_pkg;

   localparam int unsigned REQ_OP_W = 4;
   localparam int unsigned MOP_W    = 3;
   localparam int unsigned DATA_W   = 32;

   // Pipeline-side MD request encodings
   localparam logic [REQ_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [REQ_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [REQ_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [REQ_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [REQ_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [REQ_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [REQ_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [REQ_OP_W-1:0] MD_MFHI  = 4'd7;
   localparam logic [REQ_OP_W-1:0] MD_MFLO  = 4'd8;

   // MDU Multiop codes
   localparam logic [MOP_W-1:0] MOP_MULT  = 3'b000;
   localparam logic [MOP_W-1:0] MOP_MULTU = 3'b001;
   localparam logic [MOP_W-1:0] MOP_DIV   = 3'b010;
   localparam logic [MOP_W-1:0] MOP_DIVU  = 3'b011;
   localparam logic [MOP_W-1:0] MOP_MTHI  = 3'b100;
   localparam logic [MOP_W-1:0] MOP_MTLO  = 3'b101;
   localparam logic [MOP_W-1:0] MOP_IDLE  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_WRITE  = 2'd3
   } md_state_t;

   // Command payload presented to the MDU
   typedef struct packed {
      logic [MOP_W-1:0]  op;
      logic [DATA_W-1:0] rs;
      logic [DATA_W-1:0] rt;
   } md_cmd_t;

   // True for requests that start a multi-cycle MDU operation
   function automatic logic is_arith(input logic [REQ_OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [REQ_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Map an arithmetic request onto its Multiop code
   function automatic logic [MOP_W-1:0] arith_mop(input logic [REQ_OP_W-1:0] op);
      logic [MOP_W-1:0] m;
      m = MOP_IDLE;
      case (op)
         MD_MULT:  m = MOP_MULT;
         MD_MULTU: m = MOP_MULTU;
         MD_DIV:   m = MOP_DIV;
         MD_DIVU:  m = MOP_DIVU;
         default:  m = MOP_IDLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/md_lat_mon.sv
// Checks that the MDU busy window matches the expected mult/div latency.
module md_lat_mon
   import md_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             run,
   input  logic             md_busy,
   output logic             lat_err
);

   logic [CNT_W-1:0] cnt;

   // Count down the busy window; flag overrun (busy past zero) or early finish (busy drops with cnt left)
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         lat_err <= 1'b0;
      end else if (load) begin
         cnt <= load_val;
      end else if (run) begin
         if (md_busy) begin
            if (cnt == '0) begin
               lat_err <= 1'b1;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end else if (cnt != '0) begin
            lat_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/md_req_ctrl.sv
// E-stage initiator for the MDU: launches MD requests, returns mfhi/mflo, stalls while busy.
module md_req_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [REQ_OP_W-1:0] req_op,
   input  logic [DATA_W-1:0]   req_rs,
   input  logic [DATA_W-1:0]   req_rt,
   output logic                stall,
   output logic                rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic                md_start,
   output logic [MOP_W-1:0]    md_op,
   output logic [DATA_W-1:0]   md_rs,
   output logic [DATA_W-1:0]   md_rt,
   input  logic                md_busy,
   input  logic [DATA_W-1:0]   md_hi,
   input  logic [DATA_W-1:0]   md_lo,
   output logic                lat_err
);

   md_state_t        state;
   md_cmd_t          cmd_q;
   logic             req_act_c;
   logic             accept_c;
   logic             launch_c;
   logic [CNT_W-1:0] lat_load_c;

   // Only IDLE takes requests; a NONE request never holds the pipeline
   assign req_act_c  = req_valid && (req_op != MD_NONE);
   assign stall      = req_act_c && (state != ST_IDLE);
   assign accept_c   = req_act_c && !stall;
   assign launch_c   = accept_c && is_arith(req_op);
   assign lat_load_c = is_div(req_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

   assign md_op = cmd_q.op;
   assign md_rs = cmd_q.rs;
   assign md_rt = cmd_q.rt;

   // Request FSM with registered MDU command and read-return outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         md_start <= 1'b0;
         cmd_q.op <= MOP_IDLE;
         cmd_q.rs <= '0;
         cmd_q.rt <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         // Commands last one cycle; the MDU sees idle otherwise
         md_start <= 1'b0;
         cmd_q.op <= MOP_IDLE;
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept_c) begin
                  case (req_op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        state    <= ST_LAUNCH;
                        md_start <= 1'b1;
                        cmd_q.op <= arith_mop(req_op);
                        cmd_q.rs <= req_rs;
                        cmd_q.rt <= req_rt;
                     end
                     MD_MTHI: begin
                        state    <= ST_WRITE;
                        cmd_q.op <= MOP_MTHI;
                        cmd_q.rs <= req_rs;
                     end
                     MD_MTLO: begin
                        state    <= ST_WRITE;
                        cmd_q.op <= MOP_MTLO;
                        cmd_q.rs <= req_rs;
                     end
                     MD_MFHI: begin
                        rd_valid <= 1'b1;
                        rd_data  <= md_hi;
                     end
                     MD_MFLO: begin
                        rd_valid <= 1'b1;
                        rd_data  <= md_lo;
                     end
                     // Undefined op codes are consumed as no-ops
                     default: ;
                  endcase
               end
            end
            ST_LAUNCH: state <= ST_RUN;
            // Exit follows the MDU's busy, not the latency counter
            ST_RUN:    if (!md_busy) state <= ST_IDLE;
            ST_WRITE:  state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   md_lat_mon #(
      .CNT_W(CNT_W)
   ) u_lat_mon (
      .clk      (clk),
      .reset    (reset),
      .load     (launch_c),
      .load_val (lat_load_c),
      .run      (state == ST_RUN),
      .md_busy  (md_busy),
      .lat_err  (lat_err)
   );

endmodule
